// File: rtl/spi_flash_reader.sv
// Flash READ command sequencer in front of the SPI byte engine: sends opcode,
// 24-bit address and N dummy bytes, and streams the received data bytes out.
module spi_flash_reader #(
  parameter logic [7:0]  CMD_READ   = 8'h03,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             spi_en,
  output logic [7:0]       spi_datasend,
  input  logic             spi_dataflag,
  input  logic [7:0]       spi_datarecv
);

  localparam int unsigned GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  // The done/IDLE cycle is the last low cycle of spi_en, so GAP itself lasts GAP_CYCLES-1.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES < 1) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_A2,
    S_A1,
    S_A0,
    S_DATA,
    S_GAP
  } state_t;

  state_t           state, state_nxt;
  logic [23:0]      addr_q, addr_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic [LEN_W-1:0] rem_cnt, rem_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             dataflag_q;
  logic             busy_nxt, done_nxt, rd_valid_nxt, spi_en_nxt;
  logic [7:0]       rd_data_nxt, datasend_nxt;
  logic             byte_done_c;

  // One advance per engine byte, regardless of how long dataflag stays high.
  assign byte_done_c = spi_dataflag & ~dataflag_q;

  // State and registered outputs.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      rem_cnt      <= '0;
      gap_cnt      <= '0;
      dataflag_q   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= 8'h00;
      spi_en       <= 1'b0;
      spi_datasend <= 8'h00;
    end else begin
      state        <= state_nxt;
      addr_q       <= addr_nxt;
      len_q        <= len_nxt;
      rem_cnt      <= rem_nxt;
      gap_cnt      <= gap_nxt;
      dataflag_q   <= spi_dataflag;
      busy         <= busy_nxt;
      done         <= done_nxt;
      rd_valid     <= rd_valid_nxt;
      rd_data      <= rd_data_nxt;
      spi_en       <= spi_en_nxt;
      spi_datasend <= datasend_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_q;
    len_nxt      = len_q;
    rem_nxt      = rem_cnt;
    gap_nxt      = gap_cnt;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    rd_valid_nxt = 1'b0;
    rd_data_nxt  = rd_data;
    spi_en_nxt   = spi_en;
    datasend_nxt = spi_datasend;

    case (state)
      S_IDLE: begin
        gap_nxt = '0;
        if (start) begin
          if (len != '0) begin
            addr_nxt     = addr;
            len_nxt      = len;
            datasend_nxt = CMD_READ;
            spi_en_nxt   = 1'b1;
            busy_nxt     = 1'b1;
            state_nxt    = S_CMD;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end

      S_CMD: begin
        if (byte_done_c) begin
          datasend_nxt = addr_q[23:16];
          state_nxt    = S_A2;
        end
      end

      S_A2: begin
        if (byte_done_c) begin
          datasend_nxt = addr_q[15:8];
          state_nxt    = S_A1;
        end
      end

      S_A1: begin
        if (byte_done_c) begin
          datasend_nxt = addr_q[7:0];
          state_nxt    = S_A0;
        end
      end

      S_A0: begin
        if (byte_done_c) begin
          datasend_nxt = 8'h00;
          rem_nxt      = len_q;
          state_nxt    = S_DATA;
        end
      end

      S_DATA: begin
        if (byte_done_c) begin
          rd_data_nxt  = spi_datarecv;
          rd_valid_nxt = 1'b1;
          if (rem_cnt != '0) begin
            rem_nxt = rem_cnt - LEN_W'(1);
          end
          if (rem_cnt <= LEN_W'(1)) begin
            spi_en_nxt = 1'b0;
            gap_nxt    = GAP_W'(1);
            state_nxt  = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (gap_cnt >= GAP_LAST) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          gap_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end

      default: begin
        state_nxt  = S_IDLE;
        busy_nxt   = 1'b0;
        spi_en_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: an engine model serves bytes, scoreboards hold the
// expected wire bytes and returned data, and a monitor checks rd_valid/rd_data.
module tb_spi_flash_reader;

  localparam int unsigned LEN_W      = 4;
  localparam int unsigned GAP_CYCLES = 8;
  localparam logic [7:0]  CMD_READ   = 8'h03;
  localparam int          TIMEOUT    = 3000;

  logic             sclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [23:0]      addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, rd_valid, spi_en;
  logic [7:0]       rd_data, spi_datasend;
  logic             spi_dataflag = 1'b0;
  logic [7:0]       spi_datarecv = 8'h00;

  int tests = 0;
  int fails = 0;

  byte unsigned exp_sent[$];
  byte unsigned exp_rd[$];
  int rd_cnt = 0;
  int low_run = 0;
  int last_gap = 0;

  int eng_idx = 0;
  bit eng_busy = 1'b0;
  int eng_phase = 0;
  int eng_wait = 0;
  int hold_fixed = 0;

  always #5 sclk = ~sclk;

  spi_flash_reader #(
    .CMD_READ  (CMD_READ),
    .LEN_W     (LEN_W),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .sclk        (sclk),
    .rst_n       (rst_n),
    .start       (start),
    .addr        (addr),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .spi_en      (spi_en),
    .spi_datasend(spi_datasend),
    .spi_dataflag(spi_dataflag),
    .spi_datarecv(spi_datarecv)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte engine model: samples datasend at byte start, returns a random byte
  // with a dataflag pulse; bytes from the fifth on in a transaction are data.
  always @(negedge sclk) begin
    if (!rst_n) begin
      spi_dataflag = 1'b0;
      eng_busy     = 1'b0;
      eng_idx      = 0;
    end else if (!eng_busy) begin
      if (spi_en) begin
        if (exp_sent.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sent_byte: got %0h, expected no byte at %0t", spi_datasend, $time);
        end else begin
          check("sent_byte", 32'(spi_datasend), 32'(exp_sent.pop_front()));
        end
        eng_busy  = 1'b1;
        eng_phase = 0;
        eng_wait  = int'($urandom_range(1, 3));
      end else begin
        eng_idx = 0;
      end
    end else begin
      eng_wait--;
      if (eng_wait == 0) begin
        if (eng_phase == 0) begin
          spi_datarecv = 8'($urandom);
          spi_dataflag = 1'b1;
          if (eng_idx >= 4) exp_rd.push_back(spi_datarecv);
          eng_phase = 1;
          eng_wait  = (hold_fixed > 0) ? hold_fixed : int'($urandom_range(1, 3));
        end else begin
          spi_dataflag = 1'b0;
          eng_busy     = 1'b0;
          eng_idx++;
        end
      end
    end
  end

  // Output monitor: pops expected data on every rd_valid, tracks spi_en low runs.
  always @(negedge sclk) begin
    if (rst_n) begin
      if (rd_valid) begin
        rd_cnt++;
        if (exp_rd.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_data: got %0h, expected no rd_valid at %0t", rd_data, $time);
        end else begin
          check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
        end
      end
      if (!spi_en) begin
        low_run++;
      end else begin
        if (low_run > 0) last_gap = low_run;
        low_run = 0;
      end
    end
  end

  // Present a start for one cycle; caller is at a negedge with the DUT idle.
  task automatic start_read(input logic [23:0] a, input logic [LEN_W-1:0] n);
    addr  = a;
    len   = n;
    start = 1'b1;
    if (n != '0) begin
      exp_sent.push_back(CMD_READ);
      exp_sent.push_back(a[23:16]);
      exp_sent.push_back(a[15:8]);
      exp_sent.push_back(a[7:0]);
      for (int i = 0; i < int'(n); i++) exp_sent.push_back(8'h00);
    end
    @(negedge sclk);
    start = 1'b0;
    addr  = 24'($urandom);
    len   = LEN_W'($urandom);
  endtask

  // Full read; returns at the negedge where done is high (or after a zero-length request).
  task automatic do_read(input logic [23:0] a, input logic [LEN_W-1:0] n, input bit spam);
    int base;
    bit seen;
    bit busy_bad;
    base = rd_cnt;
    start_read(a, n);
    if (n == '0) begin
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
      check("zero_en", 32'(spi_en), 32'd0);
      @(negedge sclk);
      check("zero_done_width", 32'(done), 32'd0);
      check("zero_busy_after", 32'(busy), 32'd0);
      check("zero_rd_count", 32'(rd_cnt - base), 32'd0);
      return;
    end
    seen     = 1'b0;
    busy_bad = 1'b0;
    for (int cyc = 0; cyc < TIMEOUT && !seen; cyc++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (!busy) busy_bad = 1'b1;
        if (spam && busy && $urandom_range(0, 2) == 0) begin
          start = 1'b1;
          addr  = 24'($urandom);
          len   = LEN_W'($urandom);
        end else begin
          start = 1'b0;
        end
        @(negedge sclk);
      end
    end
    start = 1'b0;
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done, expected done within %0d cycles", TIMEOUT);
      exp_sent.delete();
      exp_rd.delete();
      return;
    end
    check("busy_held", 32'(busy_bad), 32'd0);
    check("busy_at_done", 32'(busy), 32'd0);
    check("rd_count", 32'(rd_cnt - base), 32'(n));
    check("sent_left", 32'(exp_sent.size()), 32'd0);
    check("rd_left", 32'(exp_rd.size()), 32'd0);
  endtask

  initial begin
    bit hit;
    bit rst_bad;
    @(negedge sclk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_spi_en", 32'(spi_en), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_datasend", 32'(spi_datasend), 32'd0);
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;
    repeat (2) @(negedge sclk);

    // Basic read at a fixed address.
    do_read(24'h123456, LEN_W'(4), 1'b0);
    @(negedge sclk);
    check("done_width", 32'(done), 32'd0);
    repeat (3) @(negedge sclk);

    // Zero-length request.
    do_read(24'hABCDEF, '0, 1'b0);
    repeat (2) @(negedge sclk);

    // Ignored starts while busy, then a back-to-back request.
    do_read(24'h00FF10, LEN_W'(3), 1'b1);
    do_read(24'h7E8190, LEN_W'(2), 1'b1);
    check("gap_len", 32'(last_gap), 32'(GAP_CYCLES));
    repeat (3) @(negedge sclk);

    // Long dataflag level.
    hold_fixed = 5;
    do_read(24'h345678, LEN_W'(2), 1'b0);
    hold_fixed = 0;
    repeat (3) @(negedge sclk);

    // Reset while the second address byte is on the wire.
    start_read(24'h5A6B7C, LEN_W'(3));
    hit = 1'b0;
    for (int cyc = 0; cyc < TIMEOUT && !hit; cyc++) begin
      @(negedge sclk);
      if (eng_busy && eng_idx == 2) hit = 1'b1;
    end
    check("reach_a1", 32'(hit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_spi_en", 32'(spi_en), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_datasend", 32'(spi_datasend), 32'd0);
    exp_sent.delete();
    exp_rd.delete();
    rst_bad = 1'b0;
    repeat (3) begin
      @(negedge sclk);
      if (done || rd_valid || spi_en) rst_bad = 1'b1;
    end
    check("reset_quiet", 32'(rst_bad), 32'd0);
    rst_n = 1'b1;
    @(negedge sclk);
    do_read(24'h000001, LEN_W'(1), 1'b0);
    repeat (3) @(negedge sclk);

    // Largest length for this counter width.
    do_read(24'hFFFFF8, LEN_W'((1 << LEN_W) - 1), 1'b0);
    repeat (3) @(negedge sclk);

    // Randomized reads, mixing back-to-back and idle spacing.
    for (int t = 0; t < 20; t++) begin
      logic [LEN_W-1:0] n;
      n = ($urandom_range(0, 9) == 0) ? '0 : LEN_W'($urandom_range(1, (1 << LEN_W) - 1));
      do_read(24'($urandom), n, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge sclk);
    end

    repeat (4) @(negedge sclk);
    check("final_sent_left", 32'(exp_sent.size()), 32'd0);
    check("final_rd_left", 32'(exp_rd.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
